// File: rtl/cw305_ascon_top.sv
// Host register shell for an Ascon-128 AEAD core on CW305: 8-bit USB bus decode, core handshake, result capture.
// Optional tag readback storage is enabled by defining CW305_ASCON_TAG_READBACK_EN.
module cw305_ascon_top #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                   usb_clk,
    input  logic                   rst,
    inout  wire  [7:0]             usb_data,
    input  logic [pADDR_WIDTH-1:0] usb_addr,
    input  logic                   usb_rdn,
    input  logic                   usb_wrn,
    input  logic                   usb_cen,
    output logic [127:0]           core_key,
    output logic [127:0]           core_nonce,
    output logic [127:0]           core_ad,
    output logic [127:0]           core_msg,
    output logic [7:0]             core_vb_ad,
    output logic [7:0]             core_vb_msg,
    output logic                   core_msg_valid,
    output logic                   core_msg_last,
    output logic                   core_msg_eot,
    output logic                   core_key_valid,
    output logic                   core_msg_select,
    output logic                   core_start,
    input  logic                   core_busy,
    input  logic                   core_read,
    input  logic                   core_ct_valid,
    input  logic                   core_tag_ready,
    input  logic                   core_done,
    input  logic [127:0]           core_ct,
    input  logic [127:0]           core_tag,
    output logic                   led1,
    output logic                   led2,
    output logic                   led3,
    output logic                   tio_trigger
);
    localparam int RSEL_W = pADDR_WIDTH - pBYTECNT_SIZE;
    typedef logic [RSEL_W-1:0] rsel_t;

    localparam rsel_t REG_CONTROL    = rsel_t'(1);
    localparam rsel_t REG_GO         = rsel_t'(2);
    localparam rsel_t REG_KEY        = rsel_t'(3);
    localparam rsel_t REG_NONCE      = rsel_t'(4);
    localparam rsel_t REG_TEXTIN     = rsel_t'(5);
    localparam rsel_t REG_TEXTIN_MSG = rsel_t'(6);
    localparam rsel_t REG_CIPHEROUT  = rsel_t'(7);
    localparam rsel_t REG_VB_AD      = rsel_t'(8);
    localparam rsel_t REG_VB_MSG     = rsel_t'(9);
    localparam rsel_t REG_TAGOUT     = rsel_t'(10);

    function automatic logic [127:0] byte_rev(input logic [127:0] v);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = v[8*(15-b) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] wr_byte128(input logic [127:0] cur, input logic [15:0] hit,
                                                input logic [7:0] d);
        logic [127:0] r;
        r = cur;
        for (int b = 0; b < 16; b++) if (hit[b]) r[8*b +: 8] = d;
        return r;
    endfunction

    rsel_t                    reg_sel;
    logic [pBYTECNT_SIZE-1:0] byte_idx;
    logic [7:0]               wdata;
    logic [15:0]              byte_hit;
    logic                     idx_in_128;
    logic [6:0]               rd_off;
    logic                     wr_en, rd_en;
    logic                     wr_ctrl, go_start, ct_wr;
    logic                     tag_flag;
    logic [7:0]               tag_byte;

    logic [7:0]   ctrl_q, ctrl_d, vb_ad_q, vb_ad_d, vb_msg_q, vb_msg_d, rdata_q, rdata_d;
    logic [127:0] key_q, key_d, nonce_q, nonce_d, ad_q, ad_d, msg_q, msg_d, ct_q, ct_d;
    logic         busy_q, busy_d, done_q, done_d, rd_flag_q, rd_flag_d, ct_flag_q, ct_flag_d;
    logic         start_q;

    assign reg_sel    = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
    assign byte_idx   = usb_addr[pBYTECNT_SIZE-1:0];
    assign wdata      = usb_data;
    assign wr_en      = !usb_cen && !usb_wrn;
    assign rd_en      = !usb_cen && !usb_rdn;
    assign idx_in_128 = ~|byte_idx[pBYTECNT_SIZE-1:4];
    assign rd_off     = {byte_idx[3:0], 3'b000};

    // One-hot byte lane select; all zero when the index is beyond a 128-bit register.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hit
            assign byte_hit[gi] = (byte_idx == pBYTECNT_SIZE'(gi));
        end
    endgenerate

    assign wr_ctrl  = wr_en && (reg_sel == REG_CONTROL) && byte_hit[0];
    assign go_start = wr_en && (reg_sel == REG_GO) && byte_hit[0] && wdata[0] && !busy_q && !core_done;
    assign ct_wr    = wr_en && (reg_sel == REG_CIPHEROUT);

`ifdef CW305_ASCON_TAG_READBACK_EN
    logic [127:0] tag_q;
    logic         tag_flag_q;

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            tag_q      <= '0;
            tag_flag_q <= 1'b0;
        end else begin
            if (core_tag_ready) tag_q <= byte_rev(core_tag);
            if (core_tag_ready)  tag_flag_q <= 1'b1;
            else if (go_start)   tag_flag_q <= 1'b0;
        end
    end

    assign tag_flag = tag_flag_q;
    assign tag_byte = idx_in_128 ? tag_q[rd_off +: 8] : 8'h00;
`else
    logic unused_tag;
    assign unused_tag = ^{core_tag_ready, core_tag};
    assign tag_flag   = 1'b0;
    assign tag_byte   = 8'h00;
`endif

    logic unused_busy_in;
    assign unused_busy_in = core_busy;

    always_comb begin
        ctrl_d    = ctrl_q;
        rd_flag_d = rd_flag_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ct_flag_d = ct_flag_q;
        ct_d      = core_ct_valid ? byte_rev(core_ct) : ct_q;
        key_d     = (wr_en && reg_sel == REG_KEY)        ? wr_byte128(key_q,   byte_hit, wdata) : key_q;
        nonce_d   = (wr_en && reg_sel == REG_NONCE)      ? wr_byte128(nonce_q, byte_hit, wdata) : nonce_q;
        ad_d      = (wr_en && reg_sel == REG_TEXTIN)     ? wr_byte128(ad_q,    byte_hit, wdata) : ad_q;
        msg_d     = (wr_en && reg_sel == REG_TEXTIN_MSG) ? wr_byte128(msg_q,   byte_hit, wdata) : msg_q;
        vb_ad_d   = (wr_en && reg_sel == REG_VB_AD  && byte_hit[0]) ? wdata : vb_ad_q;
        vb_msg_d  = (wr_en && reg_sel == REG_VB_MSG && byte_hit[0]) ? wdata : vb_msg_q;

        // A host CONTROL write beats a simultaneous core_read, but the consumed-block bit still drops.
        if (wr_ctrl)   ctrl_d = wdata;
        if (core_read) ctrl_d[0] = 1'b0;
        if (wr_ctrl)        rd_flag_d = 1'b0;
        else if (core_read) rd_flag_d = 1'b1;

        if (core_done) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (go_start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end

        if (core_ct_valid)          ct_flag_d = 1'b1;
        else if (go_start || ct_wr) ct_flag_d = 1'b0;

        rdata_d = 8'h00;
        case (reg_sel)
            REG_CONTROL:    rdata_d = byte_hit[0] ? ctrl_q : 8'h00;
            REG_GO:         rdata_d = byte_hit[0] ? {3'b000, done_q, tag_flag, ct_flag_q, rd_flag_q, busy_q} : 8'h00;
            REG_KEY:        rdata_d = idx_in_128 ? key_q[rd_off +: 8]   : 8'h00;
            REG_NONCE:      rdata_d = idx_in_128 ? nonce_q[rd_off +: 8] : 8'h00;
            REG_TEXTIN:     rdata_d = idx_in_128 ? ad_q[rd_off +: 8]    : 8'h00;
            REG_TEXTIN_MSG: rdata_d = idx_in_128 ? msg_q[rd_off +: 8]   : 8'h00;
            REG_CIPHEROUT:  rdata_d = idx_in_128 ? ct_q[rd_off +: 8]    : 8'h00;
            REG_VB_AD:      rdata_d = byte_hit[0] ? vb_ad_q  : 8'h00;
            REG_VB_MSG:     rdata_d = byte_hit[0] ? vb_msg_q : 8'h00;
            REG_TAGOUT:     rdata_d = tag_byte;
            default:        rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            vb_ad_q   <= '0;
            vb_msg_q  <= '0;
            rdata_q   <= '0;
            key_q     <= '0;
            nonce_q   <= '0;
            ad_q      <= '0;
            msg_q     <= '0;
            ct_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_flag_q <= 1'b0;
            ct_flag_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            vb_ad_q   <= vb_ad_d;
            vb_msg_q  <= vb_msg_d;
            key_q     <= key_d;
            nonce_q   <= nonce_d;
            ad_q      <= ad_d;
            msg_q     <= msg_d;
            ct_q      <= ct_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_flag_q <= rd_flag_d;
            ct_flag_q <= ct_flag_d;
            start_q   <= go_start;
            if (rd_en) rdata_q <= rdata_d;
        end
    end

    assign usb_data        = (rd_en && !rst) ? rdata_q : 8'hzz;
    assign core_key        = byte_rev(key_q);
    assign core_nonce      = byte_rev(nonce_q);
    assign core_ad         = byte_rev(ad_q);
    assign core_msg        = byte_rev(msg_q);
    assign core_vb_ad      = vb_ad_q;
    assign core_vb_msg     = vb_msg_q;
    assign core_msg_valid  = ctrl_q[0];
    assign core_msg_last   = ctrl_q[1];
    assign core_msg_eot    = ctrl_q[2];
    assign core_key_valid  = ctrl_q[3];
    assign core_msg_select = ctrl_q[4];
    assign core_start      = start_q;
    assign led1            = busy_q;
    assign led2            = ctrl_q[3];
    assign led3            = done_q;
    assign tio_trigger     = busy_q;
endmodule

// File: tb/tb_cw305_ascon_top.sv
// Directed bench for cw305_ascon_top: register table plus hand-written handshake and reset sequences.
`timescale 1ns/1ps
module tb_cw305_ascon_top;
    localparam int AW = 21;
    localparam int BW = 7;
    localparam int RW = AW - BW;

`ifdef CW305_ASCON_TAG_READBACK_EN
    localparam logic [7:0] TAGBIT = 8'h08;
    localparam logic [7:0] TAG_B0 = 8'h0f;
`else
    localparam logic [7:0] TAGBIT = 8'h00;
    localparam logic [7:0] TAG_B0 = 8'h00;
`endif

    logic usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    logic          rst;
    logic [AW-1:0] usb_addr;
    logic          usb_rdn, usb_wrn, usb_cen;
    logic          tb_oe;
    logic [7:0]    tb_wdata;
    wire  [7:0]    usb_data;
    logic [127:0]  core_key, core_nonce, core_ad, core_msg, core_ct, core_tag;
    logic [7:0]    core_vb_ad, core_vb_msg;
    logic          core_msg_valid, core_msg_last, core_msg_eot, core_key_valid, core_msg_select;
    logic          core_start, core_busy, core_read, core_ct_valid, core_tag_ready, core_done;
    logic          led1, led2, led3, tio_trigger;

    assign usb_data = tb_oe ? tb_wdata : 8'bz;

    cw305_ascon_top #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) dut (
        .usb_clk(usb_clk), .rst(rst), .usb_data(usb_data), .usb_addr(usb_addr),
        .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
        .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_msg(core_msg),
        .core_vb_ad(core_vb_ad), .core_vb_msg(core_vb_msg),
        .core_msg_valid(core_msg_valid), .core_msg_last(core_msg_last), .core_msg_eot(core_msg_eot),
        .core_key_valid(core_key_valid), .core_msg_select(core_msg_select), .core_start(core_start),
        .core_busy(core_busy), .core_read(core_read), .core_ct_valid(core_ct_valid),
        .core_tag_ready(core_tag_ready), .core_done(core_done), .core_ct(core_ct), .core_tag(core_tag),
        .led1(led1), .led2(led2), .led3(led3), .tio_trigger(tio_trigger)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    always @(negedge usb_clk) if (core_start) start_cnt <= start_cnt + 1;

    typedef struct {
        logic [7:0] wsel;
        int         widx;
        logic [7:0] wdata;
        logic [7:0] rsel;
        int         ridx;
        logic [7:0] rexp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_addr(input logic [7:0] rsel, input int idx);
        usb_addr = {RW'(rsel), BW'(idx)};
    endtask

    task automatic bus_write_ev(input logic [7:0] rsel, input int idx, input logic [7:0] d,
                                input logic rd_p, input logic done_p);
        @(negedge usb_clk);
        set_addr(rsel, idx);
        tb_wdata = d; tb_oe = 1'b1; usb_cen = 1'b0; usb_wrn = 1'b0;
        core_read = rd_p; core_done = done_p;
        @(negedge usb_clk);
        usb_cen = 1'b1; usb_wrn = 1'b1; tb_oe = 1'b0;
        core_read = 1'b0; core_done = 1'b0;
        $display("write reg 0x%02h[%0d] = 0x%02h", rsel, idx, d);
    endtask

    task automatic bus_write(input logic [7:0] rsel, input int idx, input logic [7:0] d);
        bus_write_ev(rsel, idx, d, 1'b0, 1'b0);
    endtask

    task automatic bus_read(input logic [7:0] rsel, input int idx, output logic [7:0] v);
        @(negedge usb_clk);
        set_addr(rsel, idx);
        usb_cen = 1'b0; usb_rdn = 1'b0;
        @(negedge usb_clk);
        v = usb_data;
        usb_cen = 1'b1; usb_rdn = 1'b1;
        $display("read  reg 0x%02h[%0d] -> 0x%02h", rsel, idx, v);
    endtask

    task automatic chk_reg(input string name, input logic [7:0] rsel, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(rsel, idx, v);
        check(name, {120'd0, v}, {120'd0, exp});
    endtask

    // Back-to-back read: address advances every cycle, data lags one cycle.
    task automatic burst_read(input logic [7:0] rsel, output logic [127:0] v);
        @(negedge usb_clk);
        set_addr(rsel, 0);
        usb_cen = 1'b0; usb_rdn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge usb_clk);
            v[8*i +: 8] = usb_data;
            set_addr(rsel, i + 1);
        end
        usb_cen = 1'b1; usb_rdn = 1'b1;
        $display("burst reg 0x%02h -> 0x%032h", rsel, v);
    endtask

    task automatic pulse(input int which);
        @(negedge usb_clk);
        case (which)
            0: core_read = 1'b1;
            1: core_ct_valid = 1'b1;
            2: core_tag_ready = 1'b1;
            default: core_done = 1'b1;
        endcase
        @(negedge usb_clk);
        core_read = 1'b0; core_ct_valid = 1'b0; core_tag_ready = 1'b0; core_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [11];
        logic [127:0] v128;
        logic [7:0]   v8;
        int           snap;

        vecs[0]  = '{8'h01, 0,  8'h0B, 8'h01, 0,  8'h0B};
        vecs[1]  = '{8'h08, 0,  8'h10, 8'h08, 0,  8'h10};
        vecs[2]  = '{8'h08, 1,  8'h55, 8'h08, 0,  8'h10};
        vecs[3]  = '{8'h09, 0,  8'h07, 8'h09, 0,  8'h07};
        vecs[4]  = '{8'h04, 3,  8'hA5, 8'h04, 3,  8'hA5};
        vecs[5]  = '{8'h03, 16, 8'hEE, 8'h03, 15, 8'h0F};
        vecs[6]  = '{8'h05, 15, 8'h3C, 8'h05, 15, 8'h3C};
        vecs[7]  = '{8'h06, 0,  8'hC3, 8'h06, 0,  8'hC3};
        vecs[8]  = '{8'h0F, 0,  8'h33, 8'h0F, 0,  8'h00};
        vecs[9]  = '{8'h0A, 0,  8'h99, 8'h0A, 0,  8'h00};
        vecs[10] = '{8'h07, 2,  8'h66, 8'h07, 2,  8'h00};

        rst = 1'b1; usb_addr = '0; usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen = 1'b1;
        tb_oe = 1'b0; tb_wdata = '0; core_busy = 1'b0; core_read = 1'b0; core_ct_valid = 1'b0;
        core_tag_ready = 1'b0; core_done = 1'b0; core_ct = '0; core_tag = '0;
        repeat (3) @(negedge usb_clk);
        check("reset_core_start", {127'd0, core_start}, 128'd0);
        check("reset_core_key", core_key, 128'd0);
        rst = 1'b0;
        chk_reg("reset_status", 8'h02, 0, 8'h00);
        chk_reg("reset_control", 8'h01, 0, 8'h00);

        for (int i = 0; i < 16; i++) bus_write(8'h03, i, 8'(i));
        check("key_port", core_key, 128'h000102030405060708090a0b0c0d0e0f);
        chk_reg("key_rd15", 8'h03, 15, 8'h0F);
        burst_read(8'h03, v128);
        check("key_burst", v128, 128'h0f0e0d0c0b0a09080706050403020100);

        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].wsel, vecs[i].widx, vecs[i].wdata);
            bus_read(vecs[i].rsel, vecs[i].ridx, v8);
            check($sformatf("vec%0d", i), {120'd0, v8}, {120'd0, vecs[i].rexp});
        end
        check("nonce_port", core_nonce, 128'h000000a5000000000000000000000000);
        check("ad_port", core_ad, 128'h0000000000000000000000000000003c);
        check("msg_port", core_msg, 128'hc3000000000000000000000000000000);
        check("vb_ports", {112'd0, core_vb_ad, core_vb_msg}, {112'd0, 8'h10, 8'h07});
        check("key_unchanged", core_key, 128'h000102030405060708090a0b0c0d0e0f);

        // GO handshake
        bus_write(8'h01, 0, 8'h0B);
        snap = start_cnt;
        bus_write(8'h02, 0, 8'h01);
        check("start_high", {127'd0, core_start}, 128'd1);
        @(negedge usb_clk);
        check("start_width", {127'd0, core_start}, 128'd0);
        chk_reg("go_status", 8'h02, 0, 8'h01);
        check("go_leds", {124'd0, led1, led2, tio_trigger, led3}, {124'd0, 4'b1110});
        check("go_ctrl_ports", {123'd0, core_msg_select, core_key_valid, core_msg_eot, core_msg_last, core_msg_valid},
              {123'd0, 5'b01011});
        bus_write(8'h02, 0, 8'h01);
        bus_write(8'h02, 0, 8'h01);
        bus_write(8'h02, 0, 8'h00);
        @(negedge usb_clk);
        check("start_count", 128'(start_cnt - snap), 128'd1);
        chk_reg("busy_status", 8'h02, 0, 8'h01);

        // core_read handshake
        bus_write(8'h01, 0, 8'h1F);
        pulse(0);
        chk_reg("read_status", 8'h02, 0, 8'h03);
        chk_reg("read_control", 8'h01, 0, 8'h1E);
        check("read_msg_valid", {127'd0, core_msg_valid}, 128'd0);
        bus_write(8'h01, 0, 8'h1F);
        chk_reg("read_clr_status", 8'h02, 0, 8'h01);
        chk_reg("read_clr_control", 8'h01, 0, 8'h1F);
        bus_write_ev(8'h01, 0, 8'h1F, 1'b1, 1'b0);
        chk_reg("read_coll_status", 8'h02, 0, 8'h01);
        chk_reg("read_coll_control", 8'h01, 0, 8'h1E);

        // ciphertext, done, tag
        core_ct = 128'h8a278bf8fa2812bc39e52c76205af377;
        pulse(1);
        chk_reg("ct_status", 8'h02, 0, 8'h05);
        pulse(3);
        chk_reg("done_status", 8'h02, 0, 8'h14);
        check("done_leds", {125'd0, led1, led3, tio_trigger}, {125'd0, 3'b010});
        burst_read(8'h07, v128);
        check("ct_burst", v128, 128'h77f35a20762ce539bc1228faf88b278a);
        bus_write(8'h07, 0, 8'h00);
        chk_reg("ct_clr_status", 8'h02, 0, 8'h10);
        chk_reg("ct_data_kept", 8'h07, 0, 8'h8a);
        core_tag = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        pulse(2);
        chk_reg("tag_status", 8'h02, 0, 8'h10 | TAGBIT);
        chk_reg("tag_rd0", 8'h0A, 0, TAG_B0);

        // GO colliding with core_done: done wins
        snap = start_cnt;
        bus_write_ev(8'h02, 0, 8'h01, 1'b0, 1'b1);
        chk_reg("go_done_status", 8'h02, 0, 8'h10 | TAGBIT);
        check("go_done_nostart", 128'(start_cnt - snap), 128'd0);
        bus_write(8'h02, 0, 8'h01);
        chk_reg("restart_status", 8'h02, 0, 8'h01);

        // asynchronous reset mid-operation, read strobes held low
        @(negedge usb_clk);
        set_addr(8'h03, 1);
        usb_cen = 1'b0; usb_rdn = 1'b0;
        @(negedge usb_clk);
        check("pre_reset_read", {120'd0, usb_data}, {120'd0, 8'h01});
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", {122'd0, core_start, led1, led2, led3, tio_trigger, core_key_valid}, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        check("rst_core_nonce", core_nonce, 128'd0);
        n_checks++;
        if (!(usb_data === 8'hzz || usb_data === 8'h00)) begin
            n_fail++;
            $display("FAIL rst_usb_data: got 0x%0h, expected released bus", usb_data);
        end
        repeat (2) @(negedge usb_clk);
        usb_cen = 1'b1; usb_rdn = 1'b1;
        rst = 1'b0;
        chk_reg("post_rst_status", 8'h02, 0, 8'h00);
        chk_reg("post_rst_control", 8'h01, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
